// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : CH-channel valid/ready funnel into one registered output, with
//            direct-select or round-robin arbitration. Optional packet lock
//            via macro RR_ARB_MUX_PKT_LOCK_EN.
// Revision : 1.0
// ============================================================================
module rr_arb_mux #(
    parameter int  CH = 4,
    parameter int  W  = 8,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    input  logic [CH-1:0]   in_last,
`endif
    output logic [CH-1:0]   in_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [CH-1:0] grant;
    logic [SW-1:0] gnt_id;
    logic [W-1:0]  gnt_data;
    logic [SW-1:0] rr_idx;
    logic          found;
    logic          load;
    logic          xfer;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic          lock_q, lock_d;
    logic [SW-1:0] lock_id_q, lock_id_d;
`endif

    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // A locked packet owns the grant regardless of mode/sel.
        if (lock_q) begin
            grant[lock_id_q] = in_valid[lock_id_q];
        end else
`endif
        if (!mode) begin
            grant[sel] = in_valid[sel];
        end else begin
            // CH is a power of two, so the SW-bit add wraps modulo CH.
            for (int k = 0; k < CH; k++) begin
                rr_idx = ptr_q + SW'(k);
                if (!found && in_valid[rr_idx]) begin
                    grant[rr_idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant[i]) begin
                gnt_id   = SW'(i);
                gnt_data = in_data[i*W +: W];
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign in_ready = grant & {CH{load & rst_n}};
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_id;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            if (in_last[gnt_id]) begin
                lock_d = 1'b0;
                if (mode) begin
                    ptr_d = gnt_id + SW'(1);
                end
            end else begin
                lock_d    = 1'b1;
                lock_id_d = gnt_id;
            end
`else
            if (mode) begin
                ptr_d = gnt_id + SW'(1);
            end
`endif
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Purpose  : Table-driven bench with scoreboard for rr_arb_mux (CH=4, W=8).
// Revision : 1.0
// ============================================================================
module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic [3:0]  in_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } beat_t;

    vec_t  vecs [21];
    beat_t sb [$];
    beat_t held;
    beat_t got;

    rr_arb_mux #(.CH(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2ch(input logic [3:0] oh);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) c = 2'(i);
        return c;
    endfunction

    initial begin
        // Channel data is 0x10 + channel index.
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vecs[1]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vecs[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1};
        vecs[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1};
        vecs[12] = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vecs[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0};
        vecs[18] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1};
        vecs[19] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[20] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};

        held      = '{8'h00, 2'd0};
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = 32'h13121110;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        in_last   = 4'b0000;
`endif
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset out_ch", 32'(out_ch), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        for (int v = 0; v < 21; v++) begin
            mode      = vecs[v].mode;
            sel       = vecs[v].sel;
            in_valid  = vecs[v].valid;
            out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            if (vecs[v].exp_rdy != 4'b0000)
                sb.push_back('{8'h10 + 8'(oh2ch(vecs[v].exp_rdy)), oh2ch(vecs[v].exp_rdy)});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            if (vecs[v].exp_rdy != 4'b0000) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL vec%0d scoreboard: got empty queue required one beat", v);
                end else begin
                    got  = sb.pop_front();
                    held = got;
                    chk($sformatf("vec%0d out_data", v), 32'(out_data), 32'(got.data));
                    chk($sformatf("vec%0d out_ch", v), 32'(out_ch), 32'(got.ch));
                end
            end else if (vecs[v].exp_ov) begin
                chk($sformatf("vec%0d held out_data", v), 32'(out_data), 32'(held.data));
                chk($sformatf("vec%0d held out_ch", v), 32'(out_ch), 32'(held.ch));
            end
            @(negedge clk);
        end

        // Asynchronous reset while a beat is registered; ptr was left at 3.
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset out_ch", 32'(out_ch), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data", 32'(out_data), 32'h0);
        chk("async out_ch", 32'(out_ch), 32'd0);
        chk("async in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post-reset out_ch", 32'(out_ch), 32'd0);
        chk("post-reset out_data", 32'(out_data), 32'h10);
        chk("post-reset out_valid", 32'(out_valid), 32'd1);

`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // ch0 three-beat packet while ch1 stays valid; mode flips mid-packet.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        in_data  = 32'h131211A0;
        #1;
        chk("lock b0 in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("lock b0 out_data", 32'(out_data), 32'hA0);
        @(negedge clk);
        in_data[7:0] = 8'hA1;
        #1;
        chk("lock b1 in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("lock b1 out_data", 32'(out_data), 32'hA1);
        chk("lock b1 out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        mode         = 1'b0;
        sel          = 2'd1;
        in_data[7:0] = 8'hA2;
        in_last      = 4'b0001;
        #1;
        chk("lock b2 in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("lock b2 out_data", 32'(out_data), 32'hA2);
        @(negedge clk);
        in_last = 4'b0000;
        #1;
        chk("lock release in_ready", 32'(in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("lock release out_ch", 32'(out_ch), 32'd1);
        chk("lock release out_data", 32'(out_data), 32'h11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
